// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed access latency and a one-cycle mem_ready pulse.
// Optional DMEM_ALIGN_CHECK_EN adds align_err to flag misaligned requests and suppress their effects.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            op_wr;
  logic            op_mis;
  logic [AW-1:0]   op_idx;
  logic [31:0]     op_wdata;

  logic            req;
  logic            req_mis;
  logic [AW-1:0]   req_idx;
  logic            enter_resp;
  logic            c_wr;
  logic            c_mis;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic            unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign req_idx          = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = |addr[1:0];
`else
  assign req_mis = 1'b0;
`endif

  // With zero latency the accept edge is also the RESP-entry edge, so the
  // commit has to use the request as presented rather than the latched copy.
  assign c_wr    = ZERO_LAT ? mem_write : op_wr;
  assign c_mis   = ZERO_LAT ? req_mis   : op_mis;
  assign c_idx   = ZERO_LAT ? req_idx   : op_idx;
  assign c_wdata = ZERO_LAT ? wdata     : op_wdata;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    enter_resp = 1'b0;
    case (state)
      IDLE:    enter_resp = req && ZERO_LAT;
      WAIT:    enter_resp = (cnt == 4'd0);
      default: enter_resp = 1'b0;
    endcase
  end

  // Request capture; only meaningful when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op_wr    <= mem_write;
      op_mis   <= req_mis;
      op_idx   <= req_idx;
      op_wdata <= wdata;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM; the enable is gated with rst_n so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && c_wr && !c_mis)
      mem[c_idx] <= c_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata     <= 32'd0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      mem_ready <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
      if (enter_resp) begin
        state     <= RESP;
        busy      <= 1'b1;
        mem_ready <= 1'b1;
        if (!c_wr && !c_mis)
          rdata <= mem[c_idx];
`ifdef DMEM_ALIGN_CHECK_EN
        align_err <= c_mis;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              state <= WAIT;
              cnt   <= LAT_M1;
              busy  <= 1'b1;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance,
// a reference memory model and a scoreboard queue of expected completions.
module tb_data_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        align;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        rd0, wr0, rd1, wr1;
  logic [31:0] rdata0, rdata1, rdata_s;
  logic        ready0, ready1, ready_s;
  logic        busy0, busy1, busy_s;
  logic        align0, align1, align_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [2][256];
  logic [31:0] last_rdata [2];
  exp_t        sb [$];

  assign rd0     = rd & ~sel;
  assign wr0     = wr & ~sel;
  assign rd1     = rd & sel;
  assign wr1     = wr & sel;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign ready_s = sel ? ready1 : ready0;
  assign busy_s  = sel ? busy1  : busy0;
  assign align_s = sel ? align1 : align0;

`ifndef DMEM_ALIGN_CHECK_EN
  assign align0 = 1'b0;
  assign align1 = 1'b0;
`endif

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (rd0),
    .mem_write (wr0),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata0),
    .mem_ready (ready0),
    .busy      (busy0)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .align_err (align0)
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (rd1),
    .mem_write (wr1),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata1),
    .mem_ready (ready1),
    .busy      (busy1)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .align_err (align1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input bit s);
    return s ? LAT1 : LAT0;
  endfunction

  // Issues one request on the selected instance and waits (bounded) for mem_ready.
  // exp_n is the number of falling edges from drive to the visible pulse.
  task automatic req(input bit s, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int exp_n, input string tag);
    int          n;
    bit          got;
    exp_t        e;
    logic        mis;
    logic [7:0]  idx;
    idx = a[9:2];
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (!mis) begin
      if (w)      model[s][idx] = d;
      else if (r) last_rdata[s] = model[s][idx];
    end
    sb.push_back('{rdata: last_rdata[s], align: mis});
    sel = s; rd = r; wr = w; addr = a; wdata = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n > exp_n - lat_of(s) - 1)
        check({tag, "_busy"}, 32'(busy_s), 32'd1);
      if (ready_s === 1'b1)
        got = 1'b1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, n, exp_n);
    e = sb.pop_front();
    check({tag, "_rdata"}, rdata_s, e.rdata);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, "_align"}, 32'(align_s), 32'(e.align));
`endif
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    check({tag, "_ready_low"}, 32'(ready_s), 32'd0);
    check({tag, "_busy_low"}, 32'(busy_s), 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, "_align_low"}, 32'(align_s), 32'd0);
`endif
  endtask

  initial begin
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_ready0", 32'(ready0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read, LATENCY=2
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, LAT0 + 1, "t1_wr");
    idle("t1_wr");
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, LAT0 + 1, "t1_rd");
    idle("t1_rd");

    // Zero latency, strobe held straight into the next request
    req(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, LAT1 + 1, "t2_wr");
    req(1, 1'b1, 1'b0, 32'h20, 32'h0, LAT1 + 2, "t2_rd");
    idle("t2");

    // Back-to-back read-after-write on the latency-2 instance
    req(0, 1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, LAT0 + 1, "t2b_wr");
    req(0, 1'b1, 1'b0, 32'h44, 32'h0, LAT0 + 2, "t2b_rd");
    idle("t2b");

    // Address wrap modulo DEPTH_WORDS*4
    req(0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, LAT0 + 1, "t3_wr");
    idle("t3_wr");
    req(0, 1'b1, 1'b0, 32'h000, 32'h0, LAT0 + 1, "t3_rd");
    idle("t3_rd");
    req(0, 1'b1, 1'b0, 32'hFFFF_FC10, 32'h0, LAT0 + 1, "t3_hi");
    idle("t3_hi");

    // Read and write together behave as a write only
    req(0, 1'b1, 1'b1, 32'h8, 32'h77, LAT0 + 1, "t4_rw");
    idle("t4_rw");
    req(0, 1'b1, 1'b0, 32'h8, 32'h0, LAT0 + 1, "t4_rd");
    idle("t4_rd");

    // Reset during WAIT aborts the write
    req(0, 1'b0, 1'b1, 32'h30, 32'h1111_1111, LAT0 + 1, "t5_pre");
    idle("t5_pre");
    sel = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'hFFFF_0000;
    @(negedge clk);
    check("t5_busy_wait", 32'(busy0), 32'd1);
    check("t5_noready_wait", 32'(ready0), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    check("t5_rst_ready", 32'(ready0), 32'd0);
    check("t5_rst_busy", 32'(busy0), 32'd0);
    check("t5_rst_rdata", rdata0, 32'd0);
    rst_n = 1'b1;
    last_rdata[0] = 32'd0;
    last_rdata[1] = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_ready", 32'(ready0), 32'd0);
    end
    check("t5_rdata1_rst", rdata1, 32'd0);
    req(0, 1'b1, 1'b0, 32'h30, 32'h0, LAT0 + 1, "t5_rd");
    idle("t5_rd");

    // Sub-word address bits: flagged with the align check, ignored without it
    req(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_0000, LAT0 + 1, "t6_pre");
    idle("t6_pre");
    req(0, 1'b0, 1'b1, 32'h22, 32'h55, LAT0 + 1, "t6_mis");
    idle("t6_mis");
    req(0, 1'b1, 1'b0, 32'h20, 32'h0, LAT0 + 1, "t6_rd");
    idle("t6_rd");
    req(0, 1'b1, 1'b0, 32'h13, 32'h0, LAT0 + 1, "t6_misrd");
    idle("t6_misrd");
    req(1, 1'b0, 1'b1, 32'h23, 32'h99, LAT1 + 1, "t6_z_mis");
    idle("t6_z_mis");
    req(1, 1'b1, 1'b0, 32'h20, 32'h0, LAT1 + 1, "t6_z_rd");
    idle("t6_z_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
